// File: rtl/arith4_seq.sv
// arith4_seq: operand sequencer and result register in front of the
// 8-bit add/sub/mul/div core, with valid/ready on both sides.
module arith4_seq #(
  parameter int CAPTURE_DELAY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_core_a,
  output logic [7:0] o_core_b,
  output logic [1:0] o_core_sel,
  input  logic [7:0] i_core_out,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  input  logic       i_result_ready,
  output logic       o_div0,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_OP,
    S_EXEC,
    S_OUT
  } state_t;

  localparam logic [3:0] DLY = 4'(CAPTURE_DELAY);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       in_st;
  logic       take;
  logic       fire;
  logic       last;
  logic       div_zero;

  assign in_st    = (state == S_A) || (state == S_B)
                 || (state == S_OP);
  assign o_ready  = !i_rst && in_st;
  assign o_busy   = !i_rst && (state != S_A);
  assign take     = i_valid && o_ready;
  assign fire     = o_result_valid && i_result_ready;
  assign last     = (cnt == 4'd1);
  assign div_zero = (o_core_sel == 2'd3)
                 && (o_core_b == 8'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_A:    if (take) state_nxt = S_B;
      S_B:    if (take) state_nxt = S_OP;
      S_OP:   if (take) state_nxt = S_EXEC;
      S_EXEC: if (last) state_nxt = S_OUT;
      S_OUT:  if (fire) state_nxt = S_A;
      default: state_nxt = S_A;
    endcase
  end

  // Divide-by-zero overrides whatever the core produces.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_core_a       <= 8'd0;
      o_core_b       <= 8'd0;
      o_core_sel     <= 2'd0;
      o_result       <= 8'd0;
      o_result_valid <= 1'b0;
      o_div0         <= 1'b0;
      cnt            <= 4'd0;
    end else begin
      unique case (state)
        S_A: if (take) o_core_a <= i_data;
        S_B: if (take) o_core_b <= i_data;
        S_OP: begin
          if (take) begin
            o_core_sel <= i_data[1:0];
            cnt        <= DLY;
          end
        end
        S_EXEC: begin
          cnt <= cnt - 4'd1;
          if (last) begin
            o_result_valid <= 1'b1;
            if (div_zero) begin
              o_result <= 8'hFF;
              o_div0   <= 1'b1;
            end else begin
              o_result <= i_core_out;
              o_div0   <= 1'b0;
            end
          end
        end
        S_OUT: begin
          if (fire) begin
            o_result_valid <= 1'b0;
            o_div0         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith4_seq.sv
// tb_arith4_seq: directed plus random transactions on two instances
// (CAPTURE_DELAY 1 and 4) against a behavioural arithmetic model.
module tb_arith4_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0][7:0] data;
  logic [1:0]      valid;
  logic [1:0]      ready;
  logic [1:0][7:0] ca;
  logic [1:0][7:0] cb;
  logic [1:0][1:0] cs;
  logic [1:0][7:0] cout;
  logic [1:0][7:0] res;
  logic [1:0]      rv;
  logic [1:0]      rr;
  logic [1:0]      dz;
  logic [1:0]      busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Stand-in for the combinational core; divide by zero returns junk.
  function automatic logic [7:0] core_f(
    input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 8'd0) ? 8'h5A : a / b;
    endcase
  endfunction

  assign cout[0] = core_f(ca[0], cb[0], cs[0]);
  assign cout[1] = core_f(ca[1], cb[1], cs[1]);

  arith4_seq #(.CAPTURE_DELAY(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_data(data[0]), .i_valid(valid[0]), .o_ready(ready[0]),
    .o_core_a(ca[0]), .o_core_b(cb[0]), .o_core_sel(cs[0]),
    .i_core_out(cout[0]), .o_result(res[0]),
    .o_result_valid(rv[0]), .i_result_ready(rr[0]),
    .o_div0(dz[0]), .o_busy(busy[0])
  );

  arith4_seq #(.CAPTURE_DELAY(4)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_data(data[1]), .i_valid(valid[1]), .o_ready(ready[1]),
    .o_core_a(ca[1]), .o_core_b(cb[1]), .o_core_sel(cs[1]),
    .i_core_out(cout[1]), .o_result(res[1]),
    .o_result_valid(rv[1]), .i_result_ready(rr[1]),
    .o_div0(dz[1]), .o_busy(busy[1])
  );

  // Reference: {div0, result} from plain integer arithmetic.
  function automatic logic [8:0] ref_model(
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    int x;
    int y;
    int r;
    x = int'(a);
    y = int'(b);
    case (int'(op) % 4)
      0: r = (x + y) % 256;
      1: r = (x - y + 256) % 256;
      2: r = (x * y) % 256;
      default: begin
        if (y == 0) return {1'b1, 8'hFF};
        r = x / y;
      end
    endcase
    return {1'b0, r[7:0]};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int u, input logic [7:0] v);
    int n;
    n = 0;
    data[u]  = v;
    valid[u] = 1'b1;
    while (!ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    valid[u] = 1'b0;
  endtask

  task automatic xact(input int u, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] op,
                      input int hold);
    logic [8:0] e;
    int k;
    e = ref_model(a, b, op);
    rr[u] = 1'b0;
    send(u, a);
    check("core_a", 32'(ca[u]), 32'(a));
    send(u, b);
    check("core_b", 32'(cb[u]), 32'(b));
    send(u, op);
    check("core_sel", 32'(cs[u]), 32'(op[1:0]));
    check("busy_exec", 32'(busy[u]), 32'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rv[u] && k < 40);
    check("latency", 32'(k), (u == 0) ? 32'd1 : 32'd4);
    check("result", 32'(res[u]), 32'(e[7:0]));
    check("div0", 32'(dz[u]), 32'(e[8]));
    check("ready_out", 32'(ready[u]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      valid[u] = 1'($urandom);
      data[u]  = 8'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(rv[u]), 32'd1);
      check("hold_result", 32'(res[u]), 32'(e[7:0]));
      check("hold_div0", 32'(dz[u]), 32'(e[8]));
      check("hold_ready", 32'(ready[u]), 32'd0);
    end
    valid[u] = 1'b0;
    rr[u]    = 1'b1;
    @(negedge clk);
    rr[u] = 1'b0;
    check("hs_valid", 32'(rv[u]), 32'd0);
    check("hs_div0", 32'(dz[u]), 32'd0);
    check("hs_result", 32'(res[u]), 32'(e[7:0]));
    check("hs_ready", 32'(ready[u]), 32'd1);
    check("hs_busy", 32'(busy[u]), 32'd0);
  endtask

  task automatic check_zero(input int u);
    check("rst_ready", 32'(ready[u]), 32'd0);
    check("rst_busy", 32'(busy[u]), 32'd0);
    check("rst_core_a", 32'(ca[u]), 32'd0);
    check("rst_core_b", 32'(cb[u]), 32'd0);
    check("rst_core_sel", 32'(cs[u]), 32'd0);
    check("rst_result", 32'(res[u]), 32'd0);
    check("rst_rvalid", 32'(rv[u]), 32'd0);
    check("rst_div0", 32'(dz[u]), 32'd0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    rst   = 1'b1;
    valid = '0;
    rr    = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready0", 32'(ready[0]), 32'd1);
    check("idle_ready1", 32'(ready[1]), 32'd1);

    xact(0, 8'h05, 8'h03, 8'h00, 0);
    xact(0, 8'h03, 8'h05, 8'h01, 0);
    xact(0, 8'h80, 8'h90, 8'h00, 0);
    xact(0, 8'h0C, 8'h0B, 8'h02, 0);
    xact(0, 8'h10, 8'h10, 8'h02, 0);
    xact(0, 8'h64, 8'h07, 8'h03, 0);
    xact(0, 8'h64, 8'h00, 8'h03, 0);
    xact(0, 8'h64, 8'h00, 8'hFF, 10);
    xact(0, 8'h02, 8'h02, 8'h02, 0);

    send(0, 8'h33);
    send(0, 8'h44);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    check_zero(0);
    rst = 1'b0;
    @(negedge clk);
    xact(0, 8'h09, 8'h04, 8'h01, 0);

    repeat (30) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      xact(0, a, b, 8'($urandom), int'($urandom_range(0, 3)));
    end

    xact(1, 8'h05, 8'h03, 8'h00, 0);
    repeat (6) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      xact(1, a, b, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/arith4_seq.md
# arith4_seq

Operand sequencer and result register that sits directly upstream of the combinational 4-function arithmetic core (add/sub/mul/div, 8-bit) and captures what it produces. It accepts a byte stream over a valid/ready handshake in a fixed order: operand A, operand B, then the opcode. It drives the core's operand and select inputs from registers, waits a programmable settling time, and samples the core output. It then presents the result on a second valid/ready handshake, with a divide-by-zero flag.

## Interface
- CAPTURE_DELAY, 1: cycles spent in S_EXEC before the core output is sampled; legal range 1..15.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  8  input byte, carrying A, B or the opcode. Only bits [1:0] of the opcode byte are used: 0 add, 1 sub, 2 mul, 3 div.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block accepts i_data this cycle.
- o_core_a  out  8  registered operand A, drives the core's i_d_a.
- o_core_b  out  8  registered operand B, drives the core's i_d_b.
- o_core_sel  out  2  registered opcode, drives the core's i_sel.
- i_core_out  in  8  core result (the core's o_out).
- o_result  out  8  captured result.
- o_result_valid  out  1  o_result and o_div0 are valid.
- i_result_ready  in  1  downstream accepts the result.
- o_div0  out  1  the captured operation was a divide with B == 0.
- o_busy  out  1  high in any state other than S_A.

## Operation
- States and transitions:
  - S_A: accept A, then go to S_B.
  - S_B: accept B, then go to S_OP.
  - S_OP: accept the opcode, then go to S_EXEC.
  - S_EXEC: count CAPTURE_DELAY cycles, then go to S_OUT.
  - S_OUT: hold until the result handshake, then go to S_A.
- Handshake: an input byte is accepted on a rising edge where i_valid && o_ready.
  - o_ready = !i_rst && state in {S_A, S_B, S_OP}. It is combinational from state.
  - i_valid outside those states is ignored; bytes are neither consumed nor buffered.
- Captures:
  - S_A accept: o_core_a <= i_data.
  - S_B accept: o_core_b <= i_data.
  - S_OP accept: o_core_sel <= i_data[1:0]; bits [7:2] are ignored; the counter is loaded with CAPTURE_DELAY.
- o_core_a, o_core_b and o_core_sel keep their values until overwritten by the next transaction or by reset. The core therefore sees stable inputs throughout S_EXEC and S_OUT.
- S_EXEC:
  - The counter decrements every cycle.
  - On the edge where the counter == 1: o_result <= i_core_out, o_div0 <= 0, o_result_valid <= 1, and the state goes to S_OUT.
  - Divide-by-zero (o_core_sel == 3 && o_core_b == 0): o_result <= 8'hFF and o_div0 <= 1, regardless of i_core_out.
- Arithmetic: o_result otherwise passes the core's 8-bit output through unchanged. The core truncates add, sub and mul to 8 bits (modulo 256), and its divide is unsigned integer division. This block adds no width extension.
- S_OUT:
  - o_result_valid, o_result and o_div0 are held stable while i_result_ready is low.
  - On the edge where o_result_valid && i_result_ready: o_result_valid <= 0, o_div0 <= 0, state goes to S_A. o_result keeps its last value.
- Reset (synchronous, highest priority, legal in any state including mid-transaction):
  - State goes to S_A and any partial operands are discarded.
  - Reset values: o_core_a = 0, o_core_b = 0, o_core_sel = 0, o_result = 0, o_result_valid = 0, o_div0 = 0, o_busy = 0, o_ready = 0 while i_rst is high.

## Timing
- Input: a byte can be accepted on every cycle, so with i_valid held high, A, B and the opcode are taken on three consecutive edges.
- Core inputs: they update on the edge after each handshake.
- Latency: if the opcode is accepted at edge N, o_result_valid is high after edge N+CAPTURE_DELAY.
  - For the default CAPTURE_DELAY = 1, a result appears one cycle after the opcode.
  - A full transaction takes a minimum of 3 + CAPTURE_DELAY + 1 cycles. The final cycle is the result handshake.
- Back-to-back transactions: after the result handshake the state is S_A, so o_ready is high in the very next cycle. There is no overlap between transactions and only one transaction is in flight.
- Reset and handshake on the same edge: reset wins and the result is lost.

## Test plan
- Add: reset, then stream 0x05, 0x03, 0x00 with i_result_ready high -> o_result = 0x08, o_div0 = 0, o_result_valid high one cycle after the opcode, o_ready high again on the following cycle.
- Sub and add wrap-around:
  - 0x03, 0x05, op 1 -> o_result = 0xFE.
  - 0x80, 0x90, op 0 -> o_result = 0x10.
- Mul truncation:
  - 0x0C, 0x0B, op 2 -> o_result = 0x84.
  - 0x10, 0x10, op 2 -> o_result = 0x00.
- Divide:
  - 0x64, 0x07, op 3 -> o_result = 0x0E, o_div0 = 0.
  - 0x64, 0x00, op 3 -> o_result = 0xFF, o_div0 = 1.
  - o_div0 clears on the handshake edge.
- Backpressure: hold i_result_ready low for 10 cycles and drive extra i_valid bytes -> result and o_div0 stay stable, o_ready stays 0, and the extra bytes are not consumed. Then raise i_result_ready -> o_result_valid drops and the next stream (0x02, 0x02, op 2) gives 0x04.
- Reset mid-operation: assert i_rst after A and B are accepted -> the next cycle shows S_A behaviour and all outputs are 0. A following full transaction (0x09, 0x04, op 1) gives 0x05.
- Parameter: repeat the add case with CAPTURE_DELAY = 4 -> o_result_valid rises exactly 4 cycles after the opcode handshake.
